// File: rtl/sram_arb_ctrl.sv
// sram_arb_ctrl: round-robin arbiter for two internal requesters plus the
// setup/strobe/hold sequencer for a 16-bit asynchronous SRAM. This block is
// the only driver of the shared DQ bus.
module sram_arb_ctrl #(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16,
    parameter int WAIT_CYC = 2      // strobe width in cycles, must be >= 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [1:0]        be0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [1:0]        be1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] sram_addr,
    inout  wire  [DATA_W-1:0] sram_dq,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    localparam int LANE_W = DATA_W / 2;
    localparam int CNT_W  = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYC - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               arb_en_reg;     // grants held off until the cycle after reset release
    logic               last_reg;       // port served last (1 = port 1)
    logic               port_reg;
    logic               we_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic [1:0]         be_reg;
    logic [DATA_W-1:0]  rdata_reg;
    logic [DATA_W-1:0]  lane_mask;
    logic               dq_oe;
    logic               grant0, grant1;
    logic               capture;

    // Byte-lane mask built from the latched enables; disabled lanes read as 0.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_lane
            assign lane_mask[gi*LANE_W +: LANE_W] = {LANE_W{be_reg[gi]}};
        end
    endgenerate

    // Round-robin: a lone request wins; on a tie the port not served last wins.
    assign grant0 = arb_en_reg && (state_reg == IDLE) && req0 && (!req1 || last_reg);
    assign grant1 = arb_en_reg && (state_reg == IDLE) && req1 && (!req0 || !last_reg);

    // Read data is sampled on the edge that closes the final strobe cycle.
    assign capture = (state_reg == ACCESS) && (cnt_reg == CNT_LAST) && !we_reg;

    assign sram_addr = addr_reg;
    assign rdata     = rdata_reg;
    assign sram_dq   = dq_oe ? wdata_reg : {DATA_W{1'bz}};

    // State register, strobe counter and arbitration enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            arb_en_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            arb_en_reg <= 1'b1;
        end
    end

    // Operand latch on grant, round-robin pointer update and read capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg  <= 1'b1;
            port_reg  <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            be_reg    <= '0;
            rdata_reg <= '0;
        end else begin
            if (grant0 || grant1) begin
                port_reg  <= grant1;
                last_reg  <= grant1;
                we_reg    <= grant1 ? we1    : we0;
                addr_reg  <= grant1 ? addr1  : addr0;
                wdata_reg <= grant1 ? wdata1 : wdata0;
                be_reg    <= grant1 ? be1    : be0;
            end
            if (capture) begin
                rdata_reg <= sram_dq & lane_mask;
            end
        end
    end

    // Next-state logic and SRAM strobe decode for each phase of an access.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_ub_n  = 1'b1;
        sram_lb_n  = 1'b1;
        dq_oe      = 1'b0;
        done0      = 1'b0;
        done1      = 1'b0;
        busy       = 1'b0;
        gnt0       = grant0;
        gnt1       = grant1;
        case (state_reg)
            IDLE: begin
                if (grant0 || grant1) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                busy       = 1'b1;
                sram_ce_n  = 1'b0;
                sram_ub_n  = ~be_reg[1];
                sram_lb_n  = ~be_reg[0];
                dq_oe      = we_reg;
                cnt_next   = '0;
                state_next = ACCESS;
            end
            ACCESS: begin
                busy      = 1'b1;
                sram_ce_n = 1'b0;
                sram_ub_n = ~be_reg[1];
                sram_lb_n = ~be_reg[0];
                sram_oe_n = we_reg;
                sram_we_n = ~we_reg;
                dq_oe     = we_reg;
                if (cnt_reg == CNT_LAST) begin
                    state_next = HOLD;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            HOLD: begin
                busy       = 1'b1;
                sram_ce_n  = 1'b0;
                sram_ub_n  = ~be_reg[1];
                sram_lb_n  = ~be_reg[0];
                dq_oe      = we_reg;
                done0      = ~port_reg;
                done1      = port_reg;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/sram_arb_ctrl.md
# sram_arb_ctrl

Two-port arbiter and access sequencer for the board's external 16-bit asynchronous SRAM (active-low CE/OE/WE/UB/LB, shared bidirectional DQ bus). It sits between two internal requesters and the SRAM pins. It grants one requester at a time using round-robin arbitration and generates the setup/strobe/hold sequence for each single-word read or write. It owns the DQ tristate, so no other block drives the bus.

## Interface
- ADDR_W, 18, SRAM word-address width
- DATA_W, 16, data width; byte lanes are fixed at 2
- WAIT_CYC, 2, cycles the OE_n/WE_n strobe is held low; legal range >= 1, 0 is illegal
- clk  in  1  single system clock; all logic is on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req0 / req1  in  1  access request; held with its operands until the matching gnt
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  write data
- be0 / be1  in  2  byte enables; bit1 = upper byte (UB), bit0 = lower byte (LB)
- gnt0 / gnt1  out  1  one-cycle pulse; operands are latched on this edge
- done0 / done1  out  1  one-cycle pulse on completion of that port's access
- rdata  out  DATA_W  read data, shared by both ports, valid while done is high and held until the next read completes
- busy  out  1  high whenever state != IDLE
- sram_addr  out  ADDR_W  SRAM address
- sram_dq  inout  DATA_W  SRAM data bus
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1  SRAM controls, active-low

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD.
- **IDLE**: arbitrates among the active requests.
  - With one request active, that port is granted.
  - With both active, the port not served last is granted. The last-served pointer resets to port 1, so port 0 wins the first tie.
  - On a grant: pulse gnt, latch we/addr/wdata/be and the port id, then go to SETUP.
- **SETUP** (1 cycle):
  - sram_addr valid, ce_n=0, ub_n=~be[1], lb_n=~be[0], oe_n=1, we_n=1.
  - On a write, dq is driven with the latched data.
- **ACCESS** (WAIT_CYC cycles, counted by an internal counter):
  - Read: oe_n=0.
  - Write: we_n=0, dq driven.
  - On a read, rdata is captured from dq on the clock edge that ends the last ACCESS cycle. Disabled byte lanes of rdata are forced to 0.
- **HOLD** (1 cycle):
  - oe_n=1 and we_n=1. ce_n, byte enables, address and write data are held.
  - done for the granted port is high. The next state is IDLE.
- be=2'b00 still runs the full sequence with ub_n=lb_n=1. done pulses, and on a read rdata=0.
- dq is driven only for writes, from SETUP through HOLD. It is high-Z in IDLE and for the whole of every read.
- A request is never dropped: a requester holding req without a gnt stays pending indefinitely.
- After gnt, the requester may change req and its operands freely.
- done and gnt are never high together for the same port.

## Timing
- Reset values:
  - all *_n outputs = 1, dq high-Z
  - sram_addr=0, rdata=0
  - gnt0/1=0, done0/1=0, busy=0
  - state=IDLE
- Reset is asynchronous: asserting rst_n mid-operation immediately deasserts all strobes and releases dq. The in-flight access is lost and produces no done.
- Latency: gnt in cycle T; SETUP is T+1; ACCESS is T+2 .. T+1+WAIT_CYC; HOLD and done are in T+2+WAIT_CYC.
- Throughput: one access per WAIT_CYC+3 cycles. Back-to-back grants are spaced WAIT_CYC+3 cycles apart, which leaves one idle bus cycle for turnaround.
- busy is high from T+1 through T+2+WAIT_CYC.

## Test plan
- **Reset**: rst_n=0 at any cycle → ce_n/oe_n/we_n/ub_n/lb_n=1, dq=Z, gnt/done/busy=0. Checked both asynchronously and after release.
- **Write, WAIT_CYC=2**: port0 writes 0xBEEF to addr 0x00012 with be=11; gnt0 at T → we_n=0 at T+2..T+3, dq=0xBEEF at T+1..T+4, done0 at T+4, ub_n=lb_n=0.
- **Read-back**: port1 reads addr 0x00012 from the SRAM model → oe_n=0 at T+2..T+3; the controller never drives dq; done1 at T+4 with rdata=0xBEEF.
- **Byte lanes**: write 0x1234 with be=01 over 0xBEEF → ub_n=1, lb_n=0. Readback with be=11 gives 0xBE34; readback with be=10 gives rdata=0xBE00.
- **Arbitration**: req0 and req1 held high continuously → grants go 0,1,0,1 with successive gnt pulses 5 cycles apart; each done lands on the correct port.
- **Reset mid-access**: rst_n asserted during ACCESS of a write → we_n rises without waiting for clk, dq goes Z, and no done. After release, a still-held req0 is re-granted and completes normally.
